// File: rtl/cic_comp_fir.sv
// Sixteen-tap symmetric compensation FIR behind the R=64 CIC, one shared MAC.
// Optional decimate-by-2 output selected by `define CIC_COMP_DEC2_EN.
module cic_comp_fir #(
    parameter int IN_W      = 35,
    parameter int DAT_W     = 24,
    parameter int IN_SHIFT  = 11,
    parameter int OUT_SHIFT = 11
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [IN_W-1:0]  din,
    input  logic                    din_vld,
    output logic signed [DAT_W-1:0] dout,
    output logic                    dout_vld,
    output logic                    busy,
    output logic                    ovr_err,
    output logic                    sat_err
);

    localparam int NTAP   = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DAT_W + COEF_W;
    localparam int ACC_W  = DAT_W + COEF_W + 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_RND  = 2'd2;

    localparam logic signed [COEF_W-1:0] COEF [NTAP] = '{
        -16'sd3,    16'sd6,   -16'sd14,   16'sd28,
        -16'sd55,   16'sd104, -16'sd210,  16'sd1168,
         16'sd1168, -16'sd210, 16'sd104, -16'sd55,
         16'sd28,  -16'sd14,   16'sd6,   -16'sd3
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 <<< (OUT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((1 <<< (DAT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN    = ACC_W'(-(1 <<< (DAT_W - 1)));

    logic [1:0]               state_reg;
    logic [3:0]               wr_ptr_reg;
    logic [3:0]               k_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [DAT_W-1:0]  rd_data_reg;
    logic signed [COEF_W-1:0] coef_reg;
    logic                     prod_vld_reg;
    logic signed [DAT_W-1:0]  dout_reg;
    logic                     dout_vld_reg;
    logic                     ovr_err_reg;
    logic                     sat_err_reg;
    logic signed [DAT_W-1:0]  buf_mem [NTAP];

    logic signed [DAT_W-1:0]  x_in;
    logic                     accept;
    logic                     start_run;
    logic [NTAP-1:0]          wr_sel;
    logic [3:0]               rd_addr;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  y_full;
    logic signed [DAT_W-1:0]  y_sat;
    logic                     sat_hit;
    logic                     unused_din_lsbs;

    assign x_in            = din[IN_W-1:IN_SHIFT];
    assign unused_din_lsbs = ^din[IN_SHIFT-1:0];
    assign accept          = din_vld && (state_reg == ST_IDLE);

`ifdef CIC_COMP_DEC2_EN
    logic phase_reg;

    // Only the even-phase sample kicks off a MAC run; odd samples just fill history.
    assign start_run = accept && !phase_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_reg <= 1'b0;
        end else if (accept) begin
            phase_reg <= ~phase_reg;
        end
    end
`else
    assign start_run = accept;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NTAP; gi++) begin : g_wr_sel
            assign wr_sel[gi] = accept && (wr_ptr_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                if (wr_sel[i]) begin
                    buf_mem[i] <= x_in;
                end
            end
        end
    end

    // wr_ptr already points past the newest sample, so x[n-k] sits at wr_ptr-1-k.
    assign rd_addr = wr_ptr_reg - 4'd1 - k_reg;
    assign prod    = rd_data_reg * coef_reg;

    always_comb begin
        rnd_sum = acc_reg + RND_HALF;
        y_full  = rnd_sum >>> OUT_SHIFT;
        y_sat   = y_full[DAT_W-1:0];
        sat_hit = 1'b0;
        if (y_full > Y_MAX) begin
            y_sat   = Y_MAX[DAT_W-1:0];
            sat_hit = 1'b1;
        end else if (y_full < Y_MIN) begin
            y_sat   = Y_MIN[DAT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    // Buffer read and multiply are pipelined one cycle; RND drains the last product
    // before rounding, which yields the 18-cycle input-to-output latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            k_reg        <= '0;
            acc_reg      <= '0;
            rd_data_reg  <= '0;
            coef_reg     <= '0;
            prod_vld_reg <= 1'b0;
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
            ovr_err_reg  <= 1'b0;
            sat_err_reg  <= 1'b0;
        end else begin
            dout_vld_reg <= 1'b0;
            if (din_vld && (state_reg != ST_IDLE)) begin
                ovr_err_reg <= 1'b1;
            end
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 4'd1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start_run) begin
                        acc_reg      <= '0;
                        k_reg        <= '0;
                        prod_vld_reg <= 1'b0;
                        state_reg    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    rd_data_reg  <= buf_mem[rd_addr];
                    coef_reg     <= COEF[k_reg];
                    prod_vld_reg <= 1'b1;
                    k_reg        <= k_reg + 4'd1;
                    if (prod_vld_reg) begin
                        acc_reg <= acc_reg + ACC_W'(prod);
                    end
                    if (k_reg == 4'd15) begin
                        state_reg <= ST_RND;
                    end
                end
                ST_RND: begin
                    if (prod_vld_reg) begin
                        acc_reg      <= acc_reg + ACC_W'(prod);
                        prod_vld_reg <= 1'b0;
                    end else begin
                        dout_reg     <= y_sat;
                        dout_vld_reg <= 1'b1;
                        if (sat_hit) begin
                            sat_err_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout     = dout_reg;
    assign dout_vld = dout_vld_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign ovr_err  = ovr_err_reg;
    assign sat_err  = sat_err_reg;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: reference FIR model feeds a scoreboard queue that
// is drained on every dout_vld. Honours `define CIC_COMP_DEC2_EN.
module tb_cic_comp_fir;

    logic               clk;
    logic               rstn;
    logic signed [34:0] din;
    logic               din_vld;
    logic signed [23:0] dout;
    logic               dout_vld;
    logic               busy;
    logic               ovr_err;
    logic               sat_err;

    cic_comp_fir dut (
        .clk      (clk),
        .rstn     (rstn),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .ovr_err  (ovr_err),
        .sat_err  (sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_dout   = 0;
    int n_expect = 0;
    bit prev_vld = 1'b0;

    int     h_tab [16] = '{-3, 6, -14, 28, -55, 104, -210, 1168,
                           1168, -210, 104, -55, 28, -14, 6, -3};
    longint hist [16];
    bit     model_phase = 1'b0;
    bit     model_sat   = 1'b0;

    longint exp_q [$];
    bit     sat_q [$];
    int     cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference direct-form FIR over the truncated input history.
    function automatic longint fir_out(output bit sat);
        longint acc = 0;
        longint y;
        for (int k = 0; k < 16; k++) acc += hist[k] * longint'(h_tab[k]);
        y   = (acc + 1024) >>> 11;
        sat = 1'b0;
        if (y > 8388607) begin
            y = 8388607; sat = 1'b1;
        end else if (y < -8388608) begin
            y = -8388608; sat = 1'b1;
        end
        return y;
    endfunction

    function automatic bit model_accept(input logic signed [34:0] d);
        logic signed [23:0] xv;
        bit run;
        bit s;
        longint y;
        xv = d[34:11];
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(xv);
`ifdef CIC_COMP_DEC2_EN
        run = !model_phase;
        model_phase = ~model_phase;
`else
        run = 1'b1;
`endif
        if (run) begin
            y = fir_out(s);
            if (s) model_sat = 1'b1;
            exp_q.push_back(y);
            sat_q.push_back(model_sat);
            cyc_q.push_back(cyc);
            n_expect++;
        end
        return run;
    endfunction

    task automatic send(input logic signed [34:0] d, input bit expect_accept);
        bit run;
        din     = d;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din     = '0;
        if (expect_accept) begin
            run = model_accept(d);
            check("busy_after_accept", longint'(busy), longint'(run));
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        n_expect -= exp_q.size();
        exp_q.delete();
        sat_q.delete();
        cyc_q.delete();
        for (int k = 0; k < 16; k++) hist[k] = 0;
        model_phase = 1'b0;
        model_sat   = 1'b0;
    endtask

    // Output monitor: one line per produced sample, compared against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rstn && dout_vld) begin
            n_dout++;
            check("dout_vld_width", longint'(prev_vld), 0);
            check("busy_low_at_out", longint'(busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_dout_vld", 1, 0);
            end else begin
                longint e;
                bit     es;
                int     c0;
                e  = exp_q.pop_front();
                es = sat_q.pop_front();
                c0 = cyc_q.pop_front();
                $display("out #%0d: dout=%0d expected=%0d sat_err=%0d", n_dout, dout, e, sat_err);
                check("dout", longint'(dout), e);
                check("sat_err", longint'(sat_err), longint'(es));
                check("latency", longint'(cyc - c0), 18);
            end
        end
        prev_vld = dout_vld;
    end

    initial begin
        rstn    = 1'b0;
        din     = '0;
        din_vld = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", longint'(dout), 0);
        check("rst_dout_vld", longint'(dout_vld), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovr_err", longint'(ovr_err), 0);
        check("rst_sat_err", longint'(sat_err), 0);
        @(negedge clk);
        rstn = 1'b1;
        gap(2);

        // Impulse of x=2048 followed by zeros: outputs walk the coefficient table.
        send(35'sd1 <<< 22, 1'b1);
        gap(63);
        for (int i = 0; i < 17; i++) begin
            send('0, 1'b1);
            gap(63);
        end

        // DC level 1000 settles to unity gain.
        for (int i = 0; i < 16; i++) begin
            send(35'sd1000 <<< 11, 1'b1);
            gap(63);
        end
`ifndef CIC_COMP_DEC2_EN
        check("dc_settled", longint'(dout), 1000);
`endif

        // Reset during a MAC run aborts everything at once.
        send(35'sd5 <<< 11, 1'b1);
        gap(4);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        check("midrst_dout", longint'(dout), 0);
        check("midrst_dout_vld", longint'(dout_vld), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_ovr_err", longint'(ovr_err), 0);
        check("midrst_sat_err", longint'(sat_err), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        gap(2);

        // Full-scale step from an all-zero history drives the output into clamping.
        for (int i = 0; i < 16; i++) begin
            send(35'sd8388607 <<< 11, 1'b1);
            gap(63);
        end
`ifndef CIC_COMP_DEC2_EN
        check("step_final", longint'(dout), 8388607);
        check("step_sat_sticky", longint'(sat_err), 1);
`endif

        // Second strobe 5 cycles after the first lands mid-run and is dropped.
        check("ovr_before", longint'(ovr_err), 0);
        send(35'sd3000 <<< 11, 1'b1);
        gap(4);
        send(35'sd7000 <<< 11, 1'b0);
        check("ovr_set", longint'(ovr_err), 1);
        gap(40);
        check("ovr_sticky", longint'(ovr_err), 1);

        gap(40);
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        check("dout_vld_count", longint'(n_dout), longint'(n_expect));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
